// File: rtl/bram_stream_fifo.sv
// Byte FIFO over a dual-port 1024x8 BRAM with a 2-entry output buffer; accept-to-m_valid latency 3 cycles.
// s_ready drops only when the BRAM itself is full; m_ready stalls are absorbed by the output buffer and BRAM.
module bram_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   bram_cnt;
  logic              inflight;
  logic [1:0]        ob_cnt;
  logic              ob_head;
  logic [DATA_W-1:0] ob_mem [2];
  logic              accept;
  logic              issue;
  logic              pop;
  logic [1:0]        ob_next;

  assign s_ready = !rst && (bram_cnt != DEPTH);
  assign accept  = s_valid && s_ready;
  assign m_valid = (ob_cnt != 2'd0);
  assign m_data  = ob_mem[ob_head];
  assign pop     = m_valid && m_ready;

  // ob_cnt + inflight never exceeds 2, so the buffer occupancy after this cycle fits in 2 bits.
  assign ob_next = ob_cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue   = !rst && (bram_cnt != '0) && (ob_next < 2'd2);

  assign bram_ena   = accept;
  assign bram_wea   = accept;
  assign bram_addra = wptr;
  assign bram_dina  = s_data;
  assign bram_enb   = issue;
  assign bram_web   = 1'b0;
  assign bram_addrb = rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      bram_cnt <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob_head  <= 1'b0;
      count    <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (issue)  rptr <= rptr + 1'b1;
      bram_cnt <= bram_cnt + (ADDR_W+1)'(accept) - (ADDR_W+1)'(issue);
      inflight <= issue;
      ob_cnt   <= ob_next;
      if (pop) ob_head <= ~ob_head;
      count    <= count + (ADDR_W+2)'(accept) - (ADDR_W+2)'(pop);
    end
  end

  // Tail slot is head + ob_cnt (mod 2); capture never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (inflight) ob_mem[ob_head ^ ob_cnt[0]] <= bram_doutb;
  end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Bench for bram_stream_fifo with a behavioural 1024x8 dual-port BRAM and a byte scoreboard.
module tb_bram_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [11:0] count;
  logic        bram_ena, bram_wea, bram_enb, bram_web;
  logic [9:0]  bram_addra, bram_addrb;
  logic [7:0]  bram_dina, bram_doutb;

  logic [7:0]  mem [0:1023];
  logic [7:0]  sb [$];
  logic [7:0]  exp_b;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  int          max_count = 0;
  logic        web_seen = 1'b0;

  always #5 clk = ~clk;

  bram_stream_fifo #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  // Transfers happen at the next posedge; inputs and outputs are stable at the negedge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (m_valid && m_ready) begin
        n_pops++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got %02h with nothing expected", m_data);
        end else begin
          exp_b = sb.pop_front();
          if (m_data !== exp_b) begin
            n_fail++;
            $display("FAIL sb_data: got %02h expected %02h (pop %0d)", m_data, exp_b, n_pops);
          end
        end
      end
      if (s_valid && s_ready) sb.push_back(s_data);
      if (int'(count) > max_count) max_count = int'(count);
      if (bram_web !== 1'b0) web_seen = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    step(); step();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++;
    if ({bram_ena, bram_wea, bram_enb} !== 3'b000) begin
      n_fail++; $display("FAIL rst_bram_en: got %b expected 000", {bram_ena, bram_wea, bram_enb});
    end
    rst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_latency();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    n_checks++; if (count !== 12'd1) begin n_fail++; $display("FAIL lat_count_t1: got %0d expected 1", count); end
    n_checks++; if (bram_enb !== 1'b1) begin n_fail++; $display("FAIL lat_issue_t1: got %b expected 1", bram_enb); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_m_valid_t1: got %b expected 0", m_valid); end
    step();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_m_valid_t2: got %b expected 0", m_valid); end
    step();
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL lat_m_valid_t3: got %b expected 1", m_valid); end
    n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL lat_m_data_t3: got %02h expected a5", m_data); end
    step();
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL lat_count_after_pop: got %0d expected 0", count); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_m_valid_after_pop: got %b expected 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_fill_and_swap();
    int acc = 0;
    int start;
    m_ready = 1'b0; s_valid = 1'b1;
    for (int cyc = 0; cyc < 1200 && s_ready; cyc++) begin
      s_data = 8'(acc);
      step();
      acc++;
    end
    n_checks++; if (acc != 1026) begin n_fail++; $display("FAIL fill_accepts: got %0d expected 1026", acc); end
    n_checks++; if (count !== 12'd1026) begin n_fail++; $display("FAIL fill_count: got %0d expected 1026", count); end
    s_data = 8'(acc);
    step(); step();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (count !== 12'd1026) begin n_fail++; $display("FAIL full_hold_count: got %0d expected 1026", count); end
    // One pop at full, producer keeps offering the next byte.
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL swap_s_ready_recover: got %b expected 1", s_ready); end
    n_checks++; if (count !== 12'd1025) begin n_fail++; $display("FAIL swap_count_after_pop: got %0d expected 1025", count); end
    step();
    acc++;
    s_valid = 1'b0;
    n_checks++; if (count !== 12'd1026) begin n_fail++; $display("FAIL swap_count_after_push: got %0d expected 1026", count); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL swap_s_ready_full_again: got %b expected 0", s_ready); end
    start = n_pops;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 1200 && count != 12'd0; cyc++) step();
    m_ready = 1'b0;
    n_checks++; if (n_pops - start != 1026) begin n_fail++; $display("FAIL drain_pops: got %0d expected 1026", n_pops - start); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int gaps = 0;
    int start = n_pops;
    bit seen = 1'b0;
    bit acc_now;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 3200 && (n_pops - start) < 3000; cyc++) begin
      s_valid = (sent < 3000);
      s_data = 8'(sent);
      if (m_valid) seen = 1'b1;
      else if (seen) gaps++;
      acc_now = s_valid && s_ready;
      step();
      if (acc_now) sent++;
    end
    s_valid = 1'b0;
    step(); step();
    n_checks++; if (sent != 3000) begin n_fail++; $display("FAIL stream_sent: got %0d expected 3000", sent); end
    n_checks++; if (n_pops - start != 3000) begin n_fail++; $display("FAIL stream_pops: got %0d expected 3000", n_pops - start); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL stream_count_end: got %0d expected 0", count); end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    int start = n_pops;
    max_count = 0;
    web_seen = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && count != 12'd0; cyc++) step();
    step();
    m_ready = 1'b0;
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL rand_count_end: got %0d expected 0", count); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_sb_left: got %0d expected 0", sb.size()); end
    n_checks++; if (max_count > 1026) begin n_fail++; $display("FAIL rand_max_count: got %0d expected <=1026", max_count); end
    n_checks++; if (web_seen !== 1'b0) begin n_fail++; $display("FAIL rand_bram_web: got %b expected 0", web_seen); end
    n_checks++; if (n_pops - start < 1000) begin n_fail++; $display("FAIL rand_pops: got %0d expected >=1000", n_pops - start); end
  endtask

  task automatic test_reset_midop();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      s_data = 8'(i + 7);
      step();
    end
    s_valid = 1'b0;
    step(); step();
    n_checks++; if (count !== 12'd500) begin n_fail++; $display("FAIL mid_count_500: got %0d expected 500", count); end
    // This pop triggers a read issue, so a capture is pending when rst arrives.
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++; if (count !== 12'd499) begin n_fail++; $display("FAIL mid_count_499: got %0d expected 499", count); end
    rst = 1'b1;
    step();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b expected 1", s_ready); end
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && !m_valid; cyc++) step();
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_valid: got %b expected 1", m_valid); end
    n_checks++; if (m_data !== 8'h3C) begin n_fail++; $display("FAIL mid_first_data: got %02h expected 3c", m_data); end
    step();
    m_ready = 1'b0;
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("FAIL mid_count_end: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_and_swap();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
